// File: rtl/spectrum_mag_writer.sv
// spectrum_mag_writer: turns FFT output pairs into approximate magnitudes,
// writes bins 0..511 into a double-banked spectrum RAM, tracks the per-frame
// non-DC peak and hands finished banks to the display without tearing.
module spectrum_mag_writer #(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic                 frame_start_i,
  input  logic signed [DW-1:0] re0_i,
  input  logic signed [DW-1:0] im0_i,
  input  logic signed [DW-1:0] re1_i,
  input  logic signed [DW-1:0] im1_i,
  input  logic                 disp_busy_i,
  output logic                 wr_en_o,
  output logic [7:0]           wr_addr_o,
  output logic [2*DW-1:0]      wr_data_o,
  output logic                 wr_bank_o,
  output logic                 disp_bank_o,
  output logic                 frame_done_o,
  output logic [DW-1:0]        peak_mag_o,
  output logic [8:0]           peak_bin_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DRAIN} state_t;

  state_t      r_state, w_state_next;
  logic [8:0]  r_cnt, w_cnt_next;
  logic [1:0]  r_dcnt, w_dcnt_next;
  logic        w_accept, w_first, w_overrun, w_done;
  logic [8:0]  w_pair_idx;

  // Pipeline control: valid, first-pair-of-frame marker and pair index
  logic        r_s1_vld, r_s2_vld, r_s3_vld;
  logic        r_s1_first, r_s2_first, r_s3_first;
  logic [8:0]  r_s1_idx, r_s2_idx, r_s3_idx;

  logic [2*DW-1:0] w_re_pack, w_im_pack, w_mag_pack;
  logic [DW-1:0]   w_mag0, w_mag1;

  logic            r_wr_en;
  logic [7:0]      r_wr_addr;
  logic [2*DW-1:0] r_wr_data;
  logic [DW-1:0]   r_pk_mag, w_pk_mag_next, r_peak_mag;
  logic [8:0]      r_pk_bin, w_pk_bin_next, r_peak_bin;
  logic            r_frame_done, r_overrun;
  logic            r_disp_bank, r_pend;
  logic            w_wr_ok;

  assign w_re_pack = {re1_i, re0_i};
  assign w_im_pack = {im1_i, im0_i};

  // Frame sequencing: pair acceptance, restart on overrun, drain timing
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_dcnt_next  = r_dcnt;
    w_accept     = 1'b0;
    w_first      = 1'b0;
    w_overrun    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (valid_i && frame_start_i) begin
          w_accept     = 1'b1;
          w_first      = 1'b1;
          w_cnt_next   = 9'd1;
          w_state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (valid_i) begin
          w_accept = 1'b1;
          if (frame_start_i) begin
            w_first    = 1'b1;
            w_overrun  = 1'b1;
            w_cnt_next = 9'd1;
          end else begin
            w_cnt_next = r_cnt + 9'd1;
            if (r_cnt == 9'd511) begin
              w_state_next = ST_DRAIN;
              w_dcnt_next  = 2'd0;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (valid_i && frame_start_i) begin
          w_accept     = 1'b1;
          w_first      = 1'b1;
          w_overrun    = 1'b1;
          w_cnt_next   = 9'd1;
          w_state_next = ST_CAPTURE;
        end else if (r_dcnt == 2'd3) begin
          w_done       = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_dcnt_next = r_dcnt + 2'd1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_pair_idx = w_first ? 9'd0 : r_cnt;

  // State, pair counter and drain counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 9'd0;
      r_dcnt  <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_dcnt  <= w_dcnt_next;
    end
  end

  // Control side of the three-stage magnitude pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s2_vld   <= 1'b0;
      r_s3_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s2_first <= 1'b0;
      r_s3_first <= 1'b0;
      r_s1_idx   <= 9'd0;
      r_s2_idx   <= 9'd0;
      r_s3_idx   <= 9'd0;
    end else begin
      r_s1_vld   <= w_accept;
      r_s1_first <= w_first;
      r_s1_idx   <= w_pair_idx;
      r_s2_vld   <= r_s1_vld;
      r_s2_first <= r_s1_first;
      r_s2_idx   <= r_s1_idx;
      r_s3_vld   <= r_s2_vld;
      r_s3_first <= r_s2_first;
      r_s3_idx   <= r_s2_idx;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic signed [DW-1:0] w_re, w_im;
      logic [DW-1:0]        r_a, r_b, r_mx, r_mn, r_mag;
      assign w_re = w_re_pack[gi*DW +: DW];
      assign w_im = w_im_pack[gi*DW +: DW];
      // |x| via two's complement negate; the most negative value maps to
      // 2^(DW-1) exactly when read as unsigned, then max/min, then the
      // mx + mn/4 + mn/8 estimate (fits DW bits, no saturation)
      always_ff @(posedge clk) begin
        r_a   <= w_re[DW-1] ? -w_re : w_re;
        r_b   <= w_im[DW-1] ? -w_im : w_im;
        r_mx  <= (r_a >= r_b) ? r_a : r_b;
        r_mn  <= (r_a >= r_b) ? r_b : r_a;
        r_mag <= r_mx + (r_mn >> 2) + (r_mn >> 3);
      end
      assign w_mag_pack[gi*DW +: DW] = r_mag;
    end
  endgenerate

  assign w_mag0  = w_mag_pack[DW-1:0];
  assign w_mag1  = w_mag_pack[2*DW-1:DW];
  // Mirror half (pairs 256..511) retires without touching RAM or peak
  assign w_wr_ok = r_s3_vld && !r_s3_idx[8];

  // Running-peak candidate: first pair of a frame starts from zero, DC bin
  // skipped, even bin compared before odd bin, strict > keeps lowest bin
  always_comb begin
    w_pk_mag_next = r_s3_first ? '0 : r_pk_mag;
    w_pk_bin_next = r_s3_first ? 9'd0 : r_pk_bin;
    if ((r_s3_idx[7:0] != 8'd0) && (w_mag0 > w_pk_mag_next)) begin
      w_pk_mag_next = w_mag0;
      w_pk_bin_next = {r_s3_idx[7:0], 1'b0};
    end
    if (w_mag1 > w_pk_mag_next) begin
      w_pk_mag_next = w_mag1;
      w_pk_bin_next = {r_s3_idx[7:0], 1'b1};
    end
  end

  // Write port, running peak, published peak and event pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= 8'd0;
      r_wr_data    <= '0;
      r_pk_mag     <= '0;
      r_pk_bin     <= 9'd0;
      r_peak_mag   <= '0;
      r_peak_bin   <= 9'd0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_wr_en      <= w_wr_ok;
      r_frame_done <= w_done;
      r_overrun    <= w_overrun;
      if (w_wr_ok) begin
        r_wr_addr <= r_s3_idx[7:0];
        r_wr_data <= {w_mag1, w_mag0};
        r_pk_mag  <= w_pk_mag_next;
        r_pk_bin  <= w_pk_bin_next;
      end
      if (w_done) begin
        r_peak_mag <= r_pk_mag;
        r_peak_bin <= r_pk_bin;
      end
    end
  end

  // Bank swap: only when the display is not scanning; a deferred swap is
  // served while idle, or folded into the next frame's end (single toggle)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_disp_bank <= 1'b0;
      r_pend      <= 1'b0;
    end else if (r_frame_done || (r_pend && (r_state == ST_IDLE))) begin
      if (!disp_busy_i) begin
        r_disp_bank <= ~r_disp_bank;
        r_pend      <= 1'b0;
      end else if (r_frame_done) begin
        r_pend <= 1'b1;
      end
    end
  end

  assign wr_en_o      = r_wr_en;
  assign wr_addr_o    = r_wr_addr;
  assign wr_data_o    = r_wr_data;
  assign disp_bank_o  = r_disp_bank;
  assign wr_bank_o    = ~r_disp_bank;
  assign frame_done_o = r_frame_done;
  assign peak_mag_o   = r_peak_mag;
  assign peak_bin_o   = r_peak_bin;
  assign overrun_o    = r_overrun;
  assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: doc/spectrum_mag_writer.md
# spectrum_mag_writer

Downstream of the FFT address generator: consumes the two complex FFT results read out per cycle during the output phase, computes an approximate magnitude for each bin and writes bins 0..511 into a double-banked spectrum RAM read by the VGA block. It also tracks the peak non-DC bin per frame and manages bank swapping so the display never reads a half-written frame.

## Interface
- DW, 16, signed width of each real/imaginary input component; magnitude width is also DW (unsigned)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- valid_i  in  1  input pair valid (pair = bins 2j, 2j+1)
- frame_start_i  in  1  high with the first pair (j=0) of a frame; ignored unless valid_i high
- re0_i, im0_i  in  DW  signed, bin 2j
- re1_i, im1_i  in  DW  signed, bin 2j+1
- disp_busy_i  in  1  VGA is scanning disp_bank_o; swap forbidden while high
- wr_en_o  out  1  spectrum RAM write strobe
- wr_addr_o  out  8  word address = j (0..255)
- wr_data_o  out  2*DW  {mag(2j+1), mag(2j)}
- wr_bank_o  out  1  bank being written, always ~disp_bank_o
- disp_bank_o  out  1  bank owned by display
- frame_done_o  out  1  one-cycle pulse, frame fully written
- peak_mag_o  out  DW  largest magnitude over bins 1..511 of last frame
- peak_bin_o  out  9  bin index of peak_mag_o
- overrun_o  out  1  one-cycle pulse, frame_start_i received mid-frame
- busy_o  out  1  high in CAPTURE/DRAIN

## Operation
- States: IDLE, CAPTURE, DRAIN. Pair counter cnt (9 bit), pending-swap flag.
- IDLE: valid_i&frame_start_i -> accept pair 0, cnt<=1, CAPTURE. valid_i alone ignored.
- CAPTURE: each valid_i accepts pair cnt, cnt++; gaps in valid_i allowed. Acceptance of pair 511 -> DRAIN.
- Only pairs 0..255 (bins 0..511) reach the write port; pairs 256..511 (mirror image for real input) pass through the pipeline with write suppressed.
- frame_start_i&valid_i in CAPTURE/DRAIN: overrun_o pulse, pipeline contents still retire, frame restarts with this pair as pair 0, running peak cleared, state CAPTURE; no frame_done_o for the aborted frame.
- DRAIN: 3 cycles until pipeline empty, then frame_done_o pulse, peak outputs load, state IDLE.
- Magnitude pipeline: S1 a=|re|, b=|im| (DW-bit unsigned; |-2^(DW-1)| = 2^(DW-1) exact); S2 mx=max(a,b), mn=min(a,b); S3 mag=mx+(mn>>2)+(mn>>3). Max result 1.375*2^(DW-1) < 2^DW, no saturation needed.
- Peak: updated at S3 for bins 1..511 only (bin 0 = DC excluded); strictly-greater compare, so ties keep lowest bin; bin 2j compared before 2j+1. Running peak cleared at frame start.
- Bank swap: on the frame_done_o cycle, if disp_busy_i low, disp_bank_o toggles at the next edge; else pending set. Pending executes (toggle, clear) at first edge with disp_busy_i low while state IDLE. A new frame starting with pending set writes the same undisplayed bank; pending stays set and is served at that frame's end (single toggle).

## Timing
- Reset: state IDLE, cnt 0, pending 0, all pipeline valids 0; wr_en_o 0, wr_addr_o 0, wr_data_o 0, disp_bank_o 0, wr_bank_o 1, frame_done_o 0, peak_mag_o 0, peak_bin_o 0, overrun_o 0, busy_o 0.
- Latency: pair sampled at edge n -> wr_en_o/addr/data valid after edge n+3, one cycle per pair.
- Pair 511 sampled at edge n -> frame_done_o high after edge n+4, for exactly one cycle; peak_mag_o/peak_bin_o valid from same cycle and held until next frame_done_o.
- Back-to-back frames: new frame_start_i accepted in IDLE the cycle after frame_done_o.
- Reset mid-frame: all state discarded, no write or pulse afterwards.

## Test plan
- Impulse: all pairs zero except re0=1000 at j=5 -> one nonzero write, addr 5, data {0,1000}; frame_done_o 4 cycles after pair 511; peak_mag_o=1000, peak_bin_o=10.
- Magnitude: re=-32768, im=-32768 at j=0 bin 0 -> mag 32768+8192+4096=45056; re=300, im=-400 at bin 1 -> 400+75+37=512, peak_bin_o=1 (DC excluded).
- Gapped stream: valid_i toggling every other cycle over 512 pairs -> exactly 256 writes, addrs 0..255 in order, no writes for pairs 256..511.
- Bank swap: disp_busy_i low at frame end -> disp_bank_o 0->1 next edge; busy high for 20 cycles -> toggle on first edge after busy falls; second frame during pending -> one toggle total.
- Overrun: frame_start_i at pair 100 -> overrun_o pulse, counting restarts, frame_done_o only after 512 further pairs.
- Tie/reset: equal peaks at bins 7 and 300 -> peak_bin_o=7; rst_n low at pair 200 -> all outputs reset values, no frame_done_o.
